// File: rtl/vga_scan_ctrl.sv
// VGA raster generator: pixel-rate scan counters, play-grid cell decode, and
// registered RGB/HS/VS output stage that merges object pixels over background.
module vga_scan_ctrl #(
    parameter int PIX_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int X_ORG    = 160,
    parameter int Y_ORG    = 40,
    parameter int CELL     = 20,
    parameter int GRID_W   = 16,
    parameter int GRID_H   = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [10:0] VGA_xpos,
    output logic [10:0] VGA_ypos,
    output logic [4:0]  x_rel_pos,
    output logic [4:0]  y_rel_pos,
    output logic        in_grid,
    output logic        pix_en,
    input  logic [11:0] obj_data,
    input  logic        obj_en,
    input  logic [11:0] bg_data,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic [11:0] VGA_RGB,
    output logic        frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST    = 11'(V_TOTAL - 1);
    localparam logic [10:0] HA_L      = 11'(H_ACTIVE);
    localparam logic [10:0] VA_L      = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEG    = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG    = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] X_BEG     = 11'(X_ORG);
    localparam logic [10:0] X_END     = 11'(X_ORG + GRID_W * CELL);
    localparam logic [10:0] Y_BEG     = 11'(Y_ORG);
    localparam logic [10:0] Y_END     = 11'(Y_ORG + GRID_H * CELL);
    localparam logic [10:0] CELL_LAST = 11'(CELL - 1);

    logic [DIV_W-1:0] r_div;
    logic [10:0]      r_h, r_v;
    logic [10:0]      r_xoff, r_yoff;
    logic [4:0]       r_xcell, r_ycell;
    logic [11:0]      r_rgb;
    logic             r_hs, r_vs, r_fs, r_zero_evt;

    logic        w_pix_en, w_h_wrap, w_v_wrap, w_active, w_in_grid;
    logic [10:0] w_h_nxt, w_v_nxt;

    assign w_pix_en  = (r_div == DIV_LAST);
    assign w_h_wrap  = (r_h == H_LAST);
    assign w_v_wrap  = (r_v == V_LAST);
    assign w_h_nxt   = w_h_wrap ? 11'd0 : r_h + 11'd1;
    assign w_v_nxt   = w_v_wrap ? 11'd0 : r_v + 11'd1;
    assign w_active  = (r_h < HA_L) && (r_v < VA_L);
    assign w_in_grid = (r_h >= X_BEG) && (r_h < X_END) && (r_v >= Y_BEG) && (r_v < Y_END);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div      <= '0;
            r_h        <= '0;
            r_v        <= '0;
            r_xoff     <= '0;
            r_yoff     <= '0;
            r_xcell    <= '0;
            r_ycell    <= '0;
            r_rgb      <= '0;
            r_hs       <= 1'b1;
            r_vs       <= 1'b1;
            r_fs       <= 1'b0;
            r_zero_evt <= 1'b1;
        end else begin
            // frame_start trails the clk in which the scan lands on (0,0)
            r_zero_evt <= 1'b0;
            r_fs       <= r_zero_evt;
            r_div      <= w_pix_en ? '0 : r_div + DIV_W'(1);
            if (w_pix_en) begin
                r_h <= w_h_nxt;
                // Cell counters run freely and are re-aligned at the grid origin
                if (w_h_nxt == X_BEG) begin
                    r_xoff  <= '0;
                    r_xcell <= '0;
                end else if (r_xoff == CELL_LAST) begin
                    r_xoff  <= '0;
                    r_xcell <= r_xcell + 5'd1;
                end else begin
                    r_xoff  <= r_xoff + 11'd1;
                end
                if (w_h_wrap) begin
                    r_v        <= w_v_nxt;
                    r_zero_evt <= w_v_wrap;
                    if (w_v_nxt == Y_BEG) begin
                        r_yoff  <= '0;
                        r_ycell <= '0;
                    end else if (r_yoff == CELL_LAST) begin
                        r_yoff  <= '0;
                        r_ycell <= r_ycell + 5'd1;
                    end else begin
                        r_yoff  <= r_yoff + 11'd1;
                    end
                end
                r_rgb <= w_active ? (obj_en ? obj_data : bg_data) : 12'h000;
                r_hs  <= !((r_h >= HS_BEG) && (r_h < HS_END));
                r_vs  <= !((r_v >= VS_BEG) && (r_v < VS_END));
            end
        end
    end

    assign pix_en      = w_pix_en;
    assign VGA_xpos    = r_h;
    assign VGA_ypos    = r_v;
    assign in_grid     = w_in_grid;
    assign x_rel_pos   = w_in_grid ? r_xcell : 5'd0;
    assign y_rel_pos   = w_in_grid ? r_ycell : 5'd0;
    assign VGA_RGB     = r_rgb;
    assign VGA_HS      = r_hs;
    assign VGA_VS      = r_vs;
    assign frame_start = r_fs;
endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Scoreboard bench for vga_scan_ctrl on a shrunken raster so whole frames fit
// in a short run; expected scan state is derived from the pixel index.
module tb_vga_scan_ctrl;
    localparam int P   = 4;
    localparam int HA  = 16, HFP = 2, HSY = 3, HBP = 3;
    localparam int VA  = 12, VFP = 1, VSY = 2, VBP = 2;
    localparam int HT  = HA + HFP + HSY + HBP;
    localparam int VT  = VA + VFP + VSY + VBP;
    localparam int XO  = 4, YO = 2, C = 3, GW = 3, GH = 3;
    localparam int FP  = HT * VT;
    localparam int F   = P * FP;

    typedef struct {
        int          n;
        logic [10:0] x, y;
        logic [4:0]  xr, yr;
        logic        ig;
        logic [11:0] rgb;
        logic        hs, vs;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] xpos, ypos;
    logic [4:0]  xrel, yrel;
    logic        ig, pix_en, hs, vs, fs;
    logic [11:0] obj_data = 12'h000, bg_data = 12'h000, rgb;
    logic        obj_en = 1'b0;

    exp_t q[$];
    int   checks = 0;
    int   fails  = 0;

    vga_scan_ctrl #(
        .PIX_DIV(P), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .X_ORG(XO), .Y_ORG(YO), .CELL(C), .GRID_W(GW), .GRID_H(GH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .VGA_xpos(xpos), .VGA_ypos(ypos),
        .x_rel_pos(xrel), .y_rel_pos(yrel), .in_grid(ig), .pix_en(pix_en),
        .obj_data(obj_data), .obj_en(obj_en), .bg_data(bg_data),
        .VGA_HS(hs), .VGA_VS(vs), .VGA_RGB(rgb), .frame_start(fs)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp_v, $time);
        end
    endtask

    // Directed object hits: (h,v) -> colour; everything else is background
    function automatic void obj_at(input int h, input int v, output logic en, output logic [11:0] d);
        en = 1'b1;
        if (h == 5 && v == 3)        d = 12'hF00;
        else if (h == 20 && v == 3)  d = 12'hABC;  // horizontal blank
        else if (h == 1 && v == 7)   d = 12'h123;  // border, outside grid
        else if (h == 0 && v == 0)   d = 12'hFFF;
        else if (h == 15 && v == 11) d = 12'h456;  // last active pixel
        else if (h == 3 && v == 13)  d = 12'h789;  // vertical blank
        else begin
            en = 1'b0;
            d  = 12'hBAD;
        end
    endfunction

    task automatic do_reset(input int ncyc);
        rst_n = 1'b0;
        repeat (ncyc) @(posedge clk);
        @(negedge clk);
        chk("rst_xpos", 32'(xpos), 0);
        chk("rst_ypos", 32'(ypos), 0);
        chk("rst_hs", 32'(hs), 1);
        chk("rst_vs", 32'(vs), 1);
        chk("rst_rgb", 32'(rgb), 0);
        chk("rst_pix_en", 32'(pix_en), 0);
        chk("rst_frame_start", 32'(fs), 0);
        chk("rst_in_grid", 32'(ig), 0);
        rst_n = 1'b1;
    endtask

    // Entered at the negedge of cycle 0 after reset release; leaves at cycle npix*P
    task automatic run_seg(input int npix);
        logic [11:0] prev_rgb = 12'h000;
        logic        prev_hs = 1'b1, prev_vs = 1'b1;
        logic        en;
        logic [11:0] d, bg;
        exp_t        e;
        for (int n = 0; n < npix; n++) begin
            int h, v;
            h  = n % HT;
            v  = (n / HT) % VT;
            obj_at(h, v, en, d);
            bg = (v >= 8) ? 12'h00F : 12'h0F0;
            obj_en   = en;
            obj_data = d;
            bg_data  = bg;
            e.n   = n;
            e.x   = 11'(h);
            e.y   = 11'(v);
            e.ig  = (h >= XO) && (h < XO + GW * C) && (v >= YO) && (v < YO + GH * C);
            e.xr  = e.ig ? 5'((h - XO) / C) : 5'd0;
            e.yr  = e.ig ? 5'((v - YO) / C) : 5'd0;
            e.rgb = prev_rgb;
            e.hs  = prev_hs;
            e.vs  = prev_vs;
            q.push_back(e);
            prev_rgb = (h < HA && v < VA) ? (en ? d : bg) : 12'h000;
            prev_hs  = !(h >= HA + HFP && h < HA + HFP + HSY);
            prev_vs  = !(v >= VA + VFP && v < VA + VFP + VSY);
            for (int j = 0; j < P; j++) begin
                int k;
                k = n * P + j;
                chk("pix_en", 32'(pix_en), 32'(j == P - 1));
                chk("frame_start", 32'(fs), 32'(k % F == 1));
                @(negedge clk);
            end
        end
    endtask

    // Monitor: one expected entry per pixel strobe
    initial begin
        exp_t m;
        forever begin
            @(negedge clk);
            if (pix_en === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_pix act=pix_en exp=no_strobe t=%0t", $time);
                end else begin
                    m = q.pop_front();
                    chk("xpos", 32'(xpos), 32'(m.x));
                    chk("ypos", 32'(ypos), 32'(m.y));
                    chk("in_grid", 32'(ig), 32'(m.ig));
                    chk("x_rel", 32'(xrel), 32'(m.xr));
                    chk("y_rel", 32'(yrel), 32'(m.yr));
                    chk("rgb", 32'(rgb), 32'(m.rgb));
                    chk("hs", 32'(hs), 32'(m.hs));
                    chk("vs", 32'(vs), 32'(m.vs));
                end
            end
        end
    end

    initial begin
        do_reset(3);
        run_seg(2 * FP + 50);
        do_reset(1);
        run_seg(FP + 30);
        @(negedge clk);
        chk("q_drain", 32'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
